// File: rtl/fifo_pkg.sv
// Shared defaults and lane-mask types for the FIFO byte path and its word packer.
package fifo_pkg;

  localparam int DEFAULT_DATA_W         = 8;
  localparam int DEFAULT_BYTES_PER_WORD = 4;
  localparam int MAX_LANES              = 8;

  typedef logic [MAX_LANES-1:0] keep_t;

  localparam keep_t KEEP_ALL = '1;

endpackage : fifo_pkg

// File: rtl/fifo_word_packer.sv
// Pops bytes from a 1-cycle-latency FIFO and packs them little-endian into
// words on a valid/ready master port; flush emits a partially filled word.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int BYTES_PER_WORD = DEFAULT_BYTES_PER_WORD
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  output logic                             fifo_rden,
  input  logic [DATA_W-1:0]                fifo_dout,
  input  logic                             flush,
  output logic [DATA_W*BYTES_PER_WORD-1:0] m_data,
  output logic [BYTES_PER_WORD-1:0]        m_keep,
  output logic                             m_valid,
  input  logic                             m_ready
);

  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BYTES_PER_WORD);
  localparam logic [CW-1:0] CNT_LAST = CW'(BYTES_PER_WORD - 1);
  localparam logic [BYTES_PER_WORD-1:0] KEEP_FULL = KEEP_ALL[BYTES_PER_WORD-1:0];

  typedef logic [BYTES_PER_WORD-1:0][DATA_W-1:0] lanes_t;

  lanes_t                    acc_q, acc_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      pend_q;
  logic                      flush_req_q, flush_req_d;
  lanes_t                    m_data_q, m_data_d;
  logic [BYTES_PER_WORD-1:0] m_keep_q, m_keep_d;
  logic                      m_valid_q, m_valid_d;

  lanes_t load_data;
  logic   out_free;
  logic   completing;
  logic   held_full;
  logic   flush_go;

  assign out_free   = !m_valid_q || m_ready;
  assign completing = pend_q && (cnt_q == CNT_LAST);
  assign held_full  = (cnt_q == CNT_FULL);
  assign flush_go   = flush_req_q && !pend_q && out_free;

  // A read may be issued into the last lane only when that lane's word can
  // leave this cycle, so the in-flight byte always has a free lane to land in.
  assign fifo_rden = !rst && !fifo_empty && !flush_req_q && !flush &&
                     (((cnt_q + CW'(pend_q)) < CNT_FULL) || (completing && out_free));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    m_data_d    = m_data_q;
    m_keep_d    = m_keep_q;
    m_valid_d   = m_valid_q;
    load_data   = acc_q;
    flush_req_d = flush_req_q ? !flush_go : flush;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (pend_q) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (cnt_q == CW'(i)) begin
          acc_d[i] = fifo_dout;
        end
      end
      cnt_d = cnt_q + CW'(1);
    end

    if (completing && out_free) begin
      load_data[BYTES_PER_WORD-1] = fifo_dout;
      m_data_d  = load_data;
      m_keep_d  = KEEP_FULL;
      m_valid_d = 1'b1;
      cnt_d     = '0;
    end else if (held_full && out_free) begin
      m_data_d  = acc_q;
      m_keep_d  = KEEP_FULL;
      m_valid_d = 1'b1;
      cnt_d     = '0;
    end else if (flush_go && (cnt_q != '0)) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (CW'(i) >= cnt_q) begin
          load_data[i] = '0;
        end
      end
      m_data_d  = load_data;
      m_keep_d  = KEEP_FULL >> (CNT_FULL - cnt_q);
      m_valid_d = 1'b1;
      cnt_d     = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the accumulator is cleared too; it is only a few lanes and a clean
      // reset keeps stale bytes from ever reaching m_data.
      acc_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      flush_req_q <= 1'b0;
      m_data_q    <= '0;
      m_keep_q    <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pend_q      <= fifo_rden;
      flush_req_q <= flush_req_d;
      m_data_q    <= m_data_d;
      m_keep_q    <= m_keep_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_valid = m_valid_q;

endmodule : fifo_word_packer
